// File: rtl/byte_word_assembler_if.sv
// byte_word_assembler_if: byte-in / word-out valid-ready bundle for the byte-to-word assembler
interface byte_word_assembler_if #(
    parameter int BYTES = 4
);
    localparam int W = 8 * BYTES;
    logic [7:0]   din;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         out_ready;
`ifdef BYTE_WORD_CHECKSUM_EN
    logic [7:0]   word_csum;
    modport master (output din, in_valid, out_ready, input in_ready, word_out, word_valid, word_csum);
    modport slave  (input din, in_valid, out_ready, output in_ready, word_out, word_valid, word_csum);
`else
    modport master (output din, in_valid, out_ready, input in_ready, word_out, word_valid);
    modport slave  (input din, in_valid, out_ready, output in_ready, word_out, word_valid);
`endif
endinterface

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs a byte stream into BYTES-wide words with selectable order; BYTE_WORD_CHECKSUM_EN adds a per-word XOR checksum
module byte_word_assembler #(
    parameter int BYTES = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 msb_first_i,
    byte_word_assembler_if.slave bus,
    output logic [CNT_W-1:0]     byte_count_o,
    output logic                 overflow_o
);
    localparam int W = 8 * BYTES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);
    logic [W-1:0]     sr_q, sr_d, word_q, word_d, shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wv_q, wv_d, ovf_q, ovf_d, ord_q, ord_d;
    logic             ord, rdy, acc, done, flush;
`ifdef BYTE_WORD_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d, wcs_q, wcs_d, csum_x;
`endif
    // Next-state: the completing byte only stalls when the held word is full and not draining; order is latched on a word's first byte
    always_comb begin
        rdy     = ~clear_i & ((cnt_q != LAST) | ~wv_q | bus.out_ready);
        acc     = bus.in_valid & rdy;
        done    = acc & (cnt_q == LAST);
        flush   = clear_i | done;
        ord     = (cnt_q == '0) ? msb_first_i : ord_q;
        shifted = ord ? {sr_q[W-9:0], bus.din} : {bus.din, sr_q[W-1:8]};
        ord_d   = acc ? ord : ord_q;
        sr_d    = flush ? '0 : (acc ? shifted : sr_q);
        cnt_d   = flush ? '0 : (acc ? cnt_q + 1'b1 : cnt_q);
        word_d  = done ? shifted : word_q;
        wv_d    = done | (wv_q & ~bus.out_ready);
        ovf_d   = ~clear_i & (ovf_q | (bus.in_valid & ~rdy));
`ifdef BYTE_WORD_CHECKSUM_EN
        csum_x  = csum_q ^ bus.din;
        csum_d  = flush ? '0 : (acc ? csum_x : csum_q);
        wcs_d   = done ? csum_x : wcs_q;
`endif
    end
    // State registers; reset discards any partial word and the held word
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            word_q <= '0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            ord_q  <= 1'b0;
`ifdef BYTE_WORD_CHECKSUM_EN
            csum_q <= '0;
            wcs_q  <= '0;
`endif
        end else begin
            sr_q   <= sr_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
            wv_q   <= wv_d;
            ovf_q  <= ovf_d;
            ord_q  <= ord_d;
`ifdef BYTE_WORD_CHECKSUM_EN
            csum_q <= csum_d;
            wcs_q  <= wcs_d;
`endif
        end
    end
    assign bus.in_ready   = rdy;
    assign bus.word_out   = word_q;
    assign bus.word_valid = wv_q;
    assign byte_count_o   = cnt_q;
    assign overflow_o     = ovf_q;
`ifdef BYTE_WORD_CHECKSUM_EN
    assign bus.word_csum  = wcs_q;
`endif
endmodule

// File: tb/tb_byte_word_assembler.sv
// tb_byte_word_assembler: directed steps with a word scoreboard for byte_word_assembler (BYTES=4)
module tb_byte_word_assembler;
    logic clk = 1'b0;
    logic rst, clear, msb_first, overflow;
    logic [3:0] byte_count;
    int vectors = 0;
    int errs = 0;
    logic [31:0] sb[$];

    byte_word_assembler_if #(.BYTES(4)) bus ();

    byte_word_assembler #(.BYTES(4), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .clear_i(clear),
        .msb_first_i(msb_first),
        .bus(bus),
        .byte_count_o(byte_count),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: at mid-cycle pop and compare any word being consumed, then return just after the edge
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (!rst && bus.word_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errs++;
                $error("FAIL sb_unexpected observed=%h expected=none", bus.word_out);
            end else begin
                e = sb.pop_front();
                check("sb_word", 64'(bus.word_out), 64'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.din = b;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        msb_first = 1'b0;
        bus.din = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_count", 64'(byte_count), 64'd0);
        check("rst_valid", 64'(bus.word_valid), 64'd0);
        check("rst_word", 64'(bus.word_out), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);

        // reset in the middle of a word
        msb_first = 1'b1;
        send(8'hAA);
        send(8'hBB);
        check("mid_count", 64'(byte_count), 64'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_count", 64'(byte_count), 64'd0);
        check("midrst_valid", 64'(bus.word_valid), 64'd0);
        check("midrst_word", 64'(bus.word_out), 64'd0);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        sb.push_back(32'h01020304);
        send(8'h04);
        check("msb_valid", 64'(bus.word_valid), 64'd1);
        check("msb_word", 64'(bus.word_out), 64'h01020304);
        bus.out_ready = 1'b1;
        cyc();
        check("drain_valid", 64'(bus.word_valid), 64'd0);

        // LSB-first with msb_first toggled mid-word
        msb_first = 1'b0;
        send(8'h11);
        msb_first = 1'b1;
        send(8'h22);
        send(8'h33);
        check("lsb_notyet", 64'(bus.word_valid), 64'd0);
        sb.push_back(32'h44332211);
        send(8'h44);
        check("lsb_valid", 64'(bus.word_valid), 64'd1);
        check("lsb_word", 64'(bus.word_out), 64'h44332211);
        cyc();
        check("lsb_drained", 64'(bus.word_valid), 64'd0);

        // backpressure: eight bytes with the consumer stalled
        bus.out_ready = 1'b0;
        msb_first = 1'b1;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        sb.push_back(32'hA1A2A3A4);
        send(8'hA4);
        send(8'hB1);
        send(8'hB2);
        send(8'hB3);
        check("bp_count", 64'(byte_count), 64'd3);
        bus.din = 8'hB4;
        bus.in_valid = 1'b1;
        #1;
        check("bp_ready", 64'(bus.in_ready), 64'd0);
        cyc();
        bus.in_valid = 1'b0;
        check("bp_ovf", 64'(overflow), 64'd1);
        check("bp_count_hold", 64'(byte_count), 64'd3);
        check("bp_word_hold", 64'(bus.word_out), 64'hA1A2A3A4);
        bus.out_ready = 1'b1;
        sb.push_back(32'hB1B2B3B4);
        send(8'hB4);
        check("bp_valid2", 64'(bus.word_valid), 64'd1);
        check("bp_word2", 64'(bus.word_out), 64'hB1B2B3B4);

        // drain and completion on the same edge
        bus.out_ready = 1'b0;
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        check("dc_pending", 64'(bus.word_valid), 64'd1);
        bus.out_ready = 1'b1;
        sb.push_back(32'hC1C2C3C4);
        send(8'hC4);
        check("dc_valid", 64'(bus.word_valid), 64'd1);
        check("dc_word", 64'(bus.word_out), 64'hC1C2C3C4);
        check("dc_ovf_sticky", 64'(overflow), 64'd1);
        cyc();
        check("dc_drained", 64'(bus.word_valid), 64'd0);

        // clear with a pending word and a partial word
        bus.out_ready = 1'b0;
        send(8'hD1);
        send(8'hD2);
        send(8'hD3);
        sb.push_back(32'hD1D2D3D4);
        send(8'hD4);
        send(8'hE1);
        send(8'hE2);
        clear = 1'b1;
        bus.din = 8'hE3;
        bus.in_valid = 1'b1;
        #1;
        check("clr_ready", 64'(bus.in_ready), 64'd0);
        cyc();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_count", 64'(byte_count), 64'd0);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_valid", 64'(bus.word_valid), 64'd1);
        check("clr_word", 64'(bus.word_out), 64'hD1D2D3D4);
        send(8'hF1);
        send(8'hF2);
        send(8'hF3);
        check("clr_refill", 64'(byte_count), 64'd3);
        bus.out_ready = 1'b1;
        sb.push_back(32'hF1F2F3F4);
        send(8'hF4);
        check("clr_word2", 64'(bus.word_out), 64'hF1F2F3F4);
        cyc();

`ifdef BYTE_WORD_CHECKSUM_EN
        msb_first = 1'b0;
        send(8'h0F);
        send(8'hF0);
        send(8'h55);
        sb.push_back(32'hAA55F00F);
        send(8'hAA);
        check("csum_zero", 64'(bus.word_csum), 64'h00);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        sb.push_back(32'h08040201);
        send(8'h08);
        check("csum_0f", 64'(bus.word_csum), 64'h0F);
        cyc();
`endif

        cyc();
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("end_valid", 64'(bus.word_valid), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Parametrised successor to the team's byte-wide left-shift register.
- Collects a stream of bytes into a BYTES-wide word, with selectable byte order, a byte counter and a one-word output holding register.
- Uses a valid/ready handshake on both sides and a sticky overflow flag.
- Sits between the byte-oriented serial receive path (UART/SPI byte strobes) and word-wide consumers (register file, command decoder).

Parameters:
- BYTES, 4, number of bytes per assembled word (legal range 2..16); local W = 8*BYTES.
- CNT_W, 4, width of byte counter; must satisfy 2^CNT_W > BYTES-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of partial word and overflow flag.
- msb_first  in  1  byte order for next word: 1 = first byte lands in MSB (shift left), 0 = first byte lands in LSB (shift right).
- din  in  8  input byte.
- in_valid  in  1  din is valid this cycle.
- in_ready  out  1  block accepts din this cycle (combinational).
- word_out  out  W  last completed word.
- word_valid  out  1  word_out holds an unconsumed word.
- out_ready  in  1  consumer takes word_out this cycle.
- byte_count  out  CNT_W  bytes held in current partial word (0..BYTES-1).
- overflow  out  1  sticky: a byte was offered while in_ready=0.

Behaviour:
- Reset (rst=1 at clk edge) clears all state: shift register, word_out, word_valid, byte_count, overflow, latched order = 0. Reset has priority over every other input, including mid-word; the partial word is discarded.
- Accept condition: acc = in_valid & in_ready.
- in_ready = (byte_count != BYTES-1) | ~word_valid | out_ready.
  - Partial bytes are always accepted.
  - The completing byte waits only if the holding register is full and not being drained.
- On acc with byte_count==0, msb_first is latched as the order for that whole word. Changing msb_first mid-word has no effect until the next word.
- Shift on acc:
  - Order 1: sr <= {sr[W-9:0], din}.
  - Order 0: sr <= {din, sr[W-1:8]}.
  - byte_count increments.
- Completion: acc with byte_count==BYTES-1.
  - word_out <= the fully shifted value, including this din.
  - word_valid <= 1; byte_count <= 0; sr <= 0.
  - Latency: word_valid rises on the clock edge after the last byte is accepted (1 cycle).
- Drain: word_valid & out_ready clears word_valid at the next edge, unless a completion happens in the same cycle. In that case word_valid stays 1 and word_out takes the new word, so back-to-back words are possible with no bubble.
- word_out holds its value while word_valid=0. It is updated only on completion.
- clear (no rst):
  - sr <= 0, byte_count <= 0, overflow <= 0.
  - The byte offered in the same cycle is dropped.
  - word_out and word_valid are not affected, so a pending word survives clear.
  - in_ready is forced to 0 while clear=1.
- overflow <= 1 when in_valid & ~in_ready & ~clear. It stays at 1 until clear or rst. The offered byte is lost.
- Order-0 example, BYTES=4, bytes 0x11,0x22,0x33,0x44 give word_out=0x44332211. Order 1 gives 0x11223344.

Optional Feature:
- Macro: BYTE_WORD_CHECKSUM_EN.
- Defined:
  - Adds output port word_csum (out, 8): XOR of all BYTES bytes of the completed word.
  - A running XOR accumulator is cleared with sr (completion, clear, rst).
  - word_csum is registered together with word_out and updates on the same edge.
  - Reset value is 0x00.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan (BYTES=4):
- Reset mid-word: accept 0xAA,0xBB, assert rst one cycle. Required: byte_count=0, word_valid=0, word_out=0. Then 4 new bytes 01,02,03,04 with msb_first=1 give word_out=0x01020304.
- Byte order: msb_first=0, bytes 11,22,33,44, out_ready=1. Required: word_valid=1 exactly 1 cycle after 0x44 accepted, word_out=0x44332211. Toggling msb_first after the first byte does not change the result.
- Backpressure: out_ready=0, send 8 bytes continuously.
  - Bytes 5-7 are accepted (byte_count reaches 3).
  - The 8th byte sees in_ready=0 and sets overflow=1.
  - word_out keeps word 1.
  - Raising out_ready then lets a re-sent 8th byte complete word 2.
- Simultaneous drain+complete: word_valid=1, out_ready=1, 4th byte accepted the same cycle. Required: word_valid stays 1, word_out=new word, no lost word.
- Clear: after 2 bytes and with a pending word, assert clear together with in_valid. Required: byte_count=0, overflow=0, the byte is dropped, the pending word_out is unchanged and word_valid=1.
- BYTE_WORD_CHECKSUM_EN: bytes 0x0F,0xF0,0x55,0xAA. Required: word_csum=0x00. Bytes 0x01,0x02,0x04,0x08 give word_csum=0x0F.
